cache_control: RTL and testbench
================================

CACHE_CONTROL -- requirements
Module: cache_control

Interface
REQ-001 SHALL have port: clk  in  1  sole clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have port: mem_read, mem_write  in  1 each  CPU request strobes, held until mem_resp.
REQ-004 SHALL have port: hit0, hit1  in  1 each  tag match AND valid for the indexed set, per way.
REQ-005 SHALL have port: dirty0, dirty1  in  1 each  dirty bit of the indexed set, per way.
REQ-006 SHALL have port: lru  in  1  LRU bit of the indexed set; 0 = way0 is least recently used.
REQ-007 SHALL have port: pmem_resp  in  1  physical memory completion strobe.
REQ-008 SHALL have port: mem_resp  out  1  CPU request complete.
REQ-009 SHALL have port: pmem_read, pmem_write  out  1 each  physical memory line requests.
REQ-010 SHALL have port: load0, load1  out  1 each  way-select for array loads; at most one high.
REQ-011 SHALL have port: load_data_valid_dirty, load_tag  out  1 each  array-group load requests for the downstream load demux.
REQ-012 SHALL have port: load_lru, lru_in  out  1 each  LRU array write enable and data.
REQ-013 SHALL have port: dirty_in  out  1  dirty bit written with the data/valid/dirty group.
REQ-014 SHALL have port: datain_sel  out  1  0 = CPU write-merged line, 1 = pmem line.
REQ-015 SHALL have port: pmem_addr_sel  out  1  0 = CPU address, 1 = victim tag + index.
REQ-016 SHALL have port: miss_count  out  16  miss counter.

Function
REQ-017 SHALL implement FSM states IDLE, WRITEBACK, ALLOCATE; all outputs not listed for a state/condition are 0.
REQ-018 SHALL define req = mem_read | mem_write; when both are high, the request is treated as a write.
REQ-019 In IDLE with req and (hit0|hit1), SHALL assert mem_resp combinationally in the same cycle, with load_lru=1 and lru_in=hit0.
REQ-020 SHALL resolve hit priority so way0 wins when hit0 and hit1 are both high.
REQ-021 On a write hit, SHALL assert load_data_valid_dirty=1, load_tag=0, dirty_in=1, datain_sel=0, and load0/load1 selecting the hit way.
REQ-022 In IDLE with req and no hit, SHALL register victim=lru and go to WRITEBACK if the victim's dirty bit is high, else to ALLOCATE.
REQ-023 SHALL increment miss_count by 1, wrapping 0xFFFF to 0x0000, on each IDLE miss detection only.
REQ-024 In WRITEBACK, SHALL hold pmem_write=1 and pmem_addr_sel=1 until pmem_resp, then go to ALLOCATE.
REQ-025 In ALLOCATE, SHALL hold pmem_read=1 and pmem_addr_sel=0.
REQ-026 On pmem_resp in ALLOCATE, SHALL assert load_data_valid_dirty=1, load_tag=1, dirty_in=0, datain_sel=1, and load0/load1 selecting the registered victim, then go to IDLE.
REQ-027 SHALL not assert mem_resp in WRITEBACK or ALLOCATE; the re-lookup in IDLE on the following cycle hits and responds.
REQ-028 SHALL keep the victim register constant from miss detection to return to IDLE, even if lru changes.
REQ-029 If req drops mid-miss, SHALL complete the current pmem transaction and return to IDLE without asserting mem_resp.
REQ-030 SHALL ignore pmem_resp in IDLE.
REQ-031 SHALL never assert pmem_read and pmem_write together, nor load0 and load1 together.

Reset
REQ-032 When reset is high at a clk edge, SHALL enter IDLE, clear victim to 0 and miss_count to 0, from any state.
REQ-033 SHALL have all Moore outputs at 0 in the cycle after reset, including when reset aborts WRITEBACK or ALLOCATE.
REQ-034 SHALL let reset take priority over every other transition.

Structure
REQ-035 SHALL place the state enum type cache_ctrl_state_t in lc3b_types; the counter width SHALL reuse lc3b_word.
REQ-036 SHALL be a single module with no sub-modules: one state register process plus one combinational next-state/output process.

Verification
REQ-037 SHALL cover read hit: IDLE, mem_read=1, hit1=1 -> mem_resp=1 same cycle, load_lru=1, lru_in=0, no array load.
REQ-038 SHALL cover write hit: mem_write=1, hit0=1 -> mem_resp=1, load0=1, load_data_valid_dirty=1, dirty_in=1, datain_sel=0, lru_in=1.
REQ-039 SHALL cover clean miss: lru=1, dirty1=0, pmem_resp after 3 cycles -> ALLOCATE, pmem_read high 3 cycles, then load1=1, load_tag=1, load_data_valid_dirty=1, datain_sel=1; next cycle hit1 -> mem_resp; miss_count=1.
REQ-040 SHALL cover dirty miss: lru=0, dirty0=1 -> WRITEBACK with pmem_write=1, pmem_addr_sel=1 until pmem_resp, then ALLOCATE; allocate load0=1; lru toggled mid-miss leaves victim unchanged.
REQ-041 SHALL cover reset during ALLOCATE: pmem_read drops the cycle after reset, state IDLE, miss_count=0.
REQ-042 SHALL cover miss_count wrap: preloaded 0xFFFF, then one miss -> 0x0000.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared types for the LC-3b cache controller.
package lc3b_types;

   typedef logic [15:0] lc3b_word;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      ALLOCATE  = 2'd2
   } cache_ctrl_state_t;

endpackage

// File: rtl/cache_control.sv
// Two-way set-associative cache controller: hit handling, dirty-victim
// writeback, line allocation and a free-running miss counter.
module cache_control
   import lc3b_types::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic        hit0,
   input  logic        hit1,
   input  logic        dirty0,
   input  logic        dirty1,
   input  logic        lru,
   input  logic        pmem_resp,
   output logic        mem_resp,
   output logic        pmem_read,
   output logic        pmem_write,
   output logic        load0,
   output logic        load1,
   output logic        load_data_valid_dirty,
   output logic        load_tag,
   output logic        load_lru,
   output logic        lru_in,
   output logic        dirty_in,
   output logic        datain_sel,
   output logic        pmem_addr_sel,
   output logic [15:0] miss_count
);

   cache_ctrl_state_t state_q, state_d;
   logic              victim_q, victim_d;
   lc3b_word          miss_count_q, miss_count_d;

   logic req;
   logic hit;

   // A simultaneous read and write is handled as a write.
   assign req        = mem_read | mem_write;
   assign hit        = hit0 | hit1;
   assign miss_count = miss_count_q;

   // State, victim and miss counter registers; reset wins over everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         victim_q     <= 1'b0;
         miss_count_q <= '0;
      end else begin
         state_q      <= state_d;
         victim_q     <= victim_d;
         miss_count_q <= miss_count_d;
      end
   end

   // Next-state and output decode; every output defaults low.
   always_comb begin
      state_d               = state_q;
      victim_d              = victim_q;
      miss_count_d          = miss_count_q;
      mem_resp              = 1'b0;
      pmem_read             = 1'b0;
      pmem_write            = 1'b0;
      load0                 = 1'b0;
      load1                 = 1'b0;
      load_data_valid_dirty = 1'b0;
      load_tag              = 1'b0;
      load_lru              = 1'b0;
      lru_in                = 1'b0;
      dirty_in              = 1'b0;
      datain_sel            = 1'b0;
      pmem_addr_sel         = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (req) begin
               if (hit) begin
                  // Way0 wins a double hit; the other way becomes LRU.
                  mem_resp = 1'b1;
                  load_lru = 1'b1;
                  lru_in   = hit0;
                  if (mem_write) begin
                     load_data_valid_dirty = 1'b1;
                     dirty_in              = 1'b1;
                     datain_sel            = 1'b0;
                     load0                 = hit0;
                     load1                 = ~hit0;
                  end
               end else begin
                  // Latch the victim now so later lru changes cannot move it.
                  victim_d     = lru;
                  miss_count_d = miss_count_q + 16'd1;
                  state_d      = (lru ? dirty1 : dirty0) ? WRITEBACK : ALLOCATE;
               end
            end
         end

         WRITEBACK: begin
            pmem_write    = 1'b1;
            pmem_addr_sel = 1'b1;
            if (pmem_resp) begin
               state_d = ALLOCATE;
            end
         end

         ALLOCATE: begin
            pmem_read     = 1'b1;
            pmem_addr_sel = 1'b0;
            if (pmem_resp) begin
               load_data_valid_dirty = 1'b1;
               load_tag              = 1'b1;
               dirty_in              = 1'b0;
               datain_sel            = 1'b1;
               load0                 = ~victim_q;
               load1                 = victim_q;
               state_d               = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_cache_control.sv
// Self-checking bench for cache_control: directed scenarios followed by
// random traffic, all compared against a transaction-level model.
module tb_cache_control;

   logic        clk = 1'b0;
   logic        reset, mem_read, mem_write, hit0, hit1, dirty0, dirty1, lru, pmem_resp;
   logic        mem_resp, pmem_read, pmem_write, load0, load1;
   logic        load_data_valid_dirty, load_tag, load_lru, lru_in, dirty_in;
   logic        datain_sel, pmem_addr_sel;
   logic [15:0] miss_count;

   int errors = 0;
   int checks = 0;

   // Model: is a miss outstanding, does it still need a writeback, which way.
   bit          m_busy = 0;
   bit          m_wb = 0;
   bit          m_victim = 0;
   int          m_count = 0;

   always #5 clk = ~clk;

   cache_control dut (
      .clk                   (clk),
      .reset                 (reset),
      .mem_read              (mem_read),
      .mem_write             (mem_write),
      .hit0                  (hit0),
      .hit1                  (hit1),
      .dirty0                (dirty0),
      .dirty1                (dirty1),
      .lru                   (lru),
      .pmem_resp             (pmem_resp),
      .mem_resp              (mem_resp),
      .pmem_read             (pmem_read),
      .pmem_write            (pmem_write),
      .load0                 (load0),
      .load1                 (load1),
      .load_data_valid_dirty (load_data_valid_dirty),
      .load_tag              (load_tag),
      .load_lru              (load_lru),
      .lru_in                (lru_in),
      .dirty_in              (dirty_in),
      .datain_sel            (datain_sel),
      .pmem_addr_sel         (pmem_addr_sel),
      .miss_count            (miss_count)
   );

   // One clock cycle: apply inputs, compare outputs mid-cycle, advance model.
   task automatic cyc(input string tag, input logic rst, input logic rd, input logic wr,
                      input logic h0, input logic h1, input logic d0, input logic d1,
                      input logic l, input logic pr);
      logic        e_resp, e_pr, e_pw, e_l0, e_l1, e_dvd, e_tag, e_llru, e_lin, e_din, e_dsel, e_asel;
      logic [11:0] obs, exp_v;
      logic [15:0] exp_cnt;
      bit          req;
      @(posedge clk);
      #1;
      reset = rst; mem_read = rd; mem_write = wr; hit0 = h0; hit1 = h1;
      dirty0 = d0; dirty1 = d1; lru = l; pmem_resp = pr;
      #2;
      req = rd | wr;
      {e_resp, e_pr, e_pw, e_l0, e_l1, e_dvd, e_tag, e_llru, e_lin, e_din, e_dsel, e_asel} = '0;
      if (!m_busy) begin
         if (req && (h0 || h1)) begin
            e_resp = 1; e_llru = 1; e_lin = h0;
            if (wr) begin
               e_dvd = 1; e_din = 1; e_l0 = h0; e_l1 = !h0;
            end
         end
      end else if (m_wb) begin
         e_pw = 1; e_asel = 1;
      end else begin
         e_pr = 1;
         if (pr) begin
            e_dvd = 1; e_tag = 1; e_dsel = 1; e_l0 = !m_victim; e_l1 = m_victim;
         end
      end
      exp_v = {e_resp, e_pr, e_pw, e_l0, e_l1, e_dvd, e_tag, e_llru, e_lin, e_din, e_dsel, e_asel};
      obs = {mem_resp, pmem_read, pmem_write, load0, load1, load_data_valid_dirty, load_tag,
             load_lru, lru_in, dirty_in, datain_sel, pmem_addr_sel};
      exp_cnt = 16'(m_count);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s outputs: observed=%b expected=%b", tag, obs, exp_v);
      end
      checks++;
      assert (miss_count === exp_cnt) else begin
         errors++;
         $error("FAIL %s miss_count: observed=%h expected=%h", tag, miss_count, exp_cnt);
      end
      checks++;
      assert (!(pmem_read && pmem_write) && !(load0 && load1)) else begin
         errors++;
         $error("FAIL %s exclusive: observed pr=%b pw=%b l0=%b l1=%b expected no pair high",
                tag, pmem_read, pmem_write, load0, load1);
      end
      $display("%0t %s rst=%b rd=%b wr=%b h=%b%b d=%b%b lru=%b pr=%b -> out=%b cnt=%h",
               $time, tag, rst, rd, wr, h0, h1, d0, d1, l, pr, obs, miss_count);
      // Advance the model to what the coming clock edge should produce.
      if (rst) begin
         m_busy = 0; m_wb = 0; m_victim = 0; m_count = 0;
      end else if (!m_busy) begin
         if (req && !(h0 || h1)) begin
            m_busy = 1; m_victim = l; m_wb = l ? d1 : d0;
            m_count = (m_count + 1) % 65536;
         end
      end else if (m_wb) begin
         if (pr) m_wb = 0;
      end else if (pr) begin
         m_busy = 0;
      end
   endtask

   initial begin
      reset = 1; mem_read = 0; mem_write = 0; hit0 = 0; hit1 = 0;
      dirty0 = 0; dirty1 = 0; lru = 0; pmem_resp = 0;
      repeat (2) @(posedge clk);

      //      tag          rst rd wr h0 h1 d0 d1 lru pr
      cyc("reset_state",   0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc("idle_presp",    0, 0, 0, 0, 0, 0, 0, 0, 1);
      // Read hit on way1.
      cyc("read_hit1",     0, 1, 0, 0, 1, 0, 0, 0, 0);
      // Write hit on way0, and a double hit where way0 must win.
      cyc("write_hit0",    0, 0, 1, 1, 0, 0, 0, 1, 0);
      cyc("write_hit_both",0, 1, 1, 1, 1, 0, 0, 0, 0);
      cyc("write_hit1",    0, 0, 1, 0, 1, 1, 1, 0, 0);
      // Clean miss, victim way1, memory answers after three cycles.
      cyc("clean_miss",    0, 1, 0, 0, 0, 0, 0, 1, 0);
      cyc("alloc_wait1",   0, 1, 0, 0, 0, 0, 0, 1, 0);
      cyc("alloc_wait2",   0, 1, 0, 0, 0, 0, 0, 1, 0);
      cyc("alloc_done",    0, 1, 0, 0, 0, 0, 0, 1, 1);
      cyc("relookup_hit1", 0, 1, 0, 0, 1, 0, 0, 1, 0);
      // Dirty miss on way0 with lru toggling while the miss is outstanding.
      cyc("dirty_miss",    0, 0, 1, 0, 0, 1, 0, 0, 0);
      cyc("wb_wait",       0, 0, 1, 0, 0, 1, 0, 1, 0);
      cyc("wb_done",       0, 0, 1, 0, 0, 1, 0, 1, 1);
      cyc("alloc_wait",    0, 0, 1, 0, 0, 1, 0, 1, 0);
      cyc("alloc_done0",   0, 0, 1, 0, 0, 1, 0, 1, 1);
      cyc("relookup_hit0", 0, 0, 1, 1, 0, 1, 0, 1, 0);
      // Request withdrawn mid-miss: line still fills, no response.
      cyc("drop_miss",     0, 1, 0, 0, 0, 0, 1, 1, 0);
      cyc("drop_wb",       0, 0, 0, 0, 0, 0, 1, 0, 1);
      cyc("drop_alloc",    0, 0, 0, 0, 0, 0, 1, 0, 1);
      cyc("drop_idle",     0, 0, 0, 0, 0, 0, 0, 0, 0);
      // Reset while allocating.
      cyc("rst_miss",      0, 1, 0, 0, 0, 0, 0, 0, 0);
      cyc("rst_alloc",     0, 1, 0, 0, 0, 0, 0, 0, 0);
      cyc("rst_assert",    1, 1, 0, 0, 0, 0, 0, 0, 0);
      cyc("rst_after",     0, 0, 0, 0, 0, 0, 0, 0, 1);
      // Reset while writing back.
      cyc("rst_wmiss",     0, 1, 0, 0, 0, 0, 1, 1, 0);
      cyc("rst_wb",        1, 1, 0, 0, 0, 0, 1, 1, 0);
      cyc("rst_wb_after",  0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Counter wrap: preload 0xFFFF, then one miss.
      @(negedge clk);
      force dut.miss_count_q = 16'hFFFF;
      #1;
      release dut.miss_count_q;
      m_count = 16'hFFFF;
      cyc("wrap_preload",  0, 1, 0, 0, 0, 0, 0, 0, 0);
      cyc("wrap_alloc",    0, 1, 0, 0, 0, 0, 0, 0, 1);
      cyc("wrap_zero",     0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         cyc("random", ($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             ($urandom_range(0, 2) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
